ser_nto1: RTL and testbench

Parametrised wide-to-narrow serializer for the PHY transmit path, the generalised successor to the fixed 32-to-8 byte splitter. Accepts IN_W-bit words over a valid/ready handshake and emits them as RATIO = IN_W/OUT_W consecutive OUT_W-bit slices at the fast clock. Slice order is selectable per word. A one-word holding register sustains gap-free streaming. A word, once accepted, is always emitted in full.

---
 rtl/phy_pkg.sv | 22 ++
 rtl/ser_slice_sel.sv | 27 ++
 rtl/ser_nto1.sv | 141 ++++++++++++++
 tb/tb_ser_nto1.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY transmit-path types and constants.
// Used by the serializer and its slice mux.
package phy_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_st_t;

  localparam logic [7:0] K28_5_SYM = 8'hBC;

  localparam int DW_STRIPE = 32;
  localparam int DW_LANE   = 8;

  function automatic int ser_ratio(
    input int iw,
    input int ow
  );
    return iw / ow;
  endfunction

endpackage

// File: rtl/ser_slice_sel.sv
// Combinational slice mux: picks OUT_W-bit slice k of word w.
// msb selects whether slice 0 is the top or bottom of w.
module ser_slice_sel
  import phy_pkg::*;
#(
  parameter  int IN_W  = DW_STRIPE,
  parameter  int OUT_W = DW_LANE,
  localparam int RATIO = IN_W / OUT_W,
  localparam int SW    = $clog2(RATIO)
) (
  input  logic [IN_W-1:0]  w,
  input  logic [SW-1:0]    k,
  input  logic             msb,
  output logic [OUT_W-1:0] s
);

  always_comb begin
    s = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (k == SW'(i)) begin
        s = msb ? w[IN_W-1-i*OUT_W -: OUT_W]
                : w[i*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/ser_nto1.sv
// Wide-to-narrow serializer with one-word hold register.
// Optional idle fill on out_data: define SER_IDLE_FILL_EN.
module ser_nto1
  import phy_pkg::*;
#(
  parameter int              IN_W     = DW_STRIPE,
  parameter int              OUT_W    = DW_LANE,
  parameter logic [OUT_W-1:0] IDLE_SYM = OUT_W'(K28_5_SYM)
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_msb_first,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_first
);

  localparam int RATIO = ser_ratio(IN_W, OUT_W);
  localparam int SW    = $clog2(RATIO);
  localparam logic [SW-1:0] LAST = SW'(RATIO - 1);

`ifdef SER_IDLE_FILL_EN
  localparam logic [OUT_W-1:0] FILL = IDLE_SYM;
`else
  // Without fill the idle symbol collapses to zero.
  localparam logic [OUT_W-1:0] FILL = IDLE_SYM & '0;
`endif

  ser_st_t          st, st_n;
  logic [IN_W-1:0]  cur, cur_n;
  logic             cur_msb, cur_msb_n;
  logic [SW-1:0]    sel, sel_n;
  logic [IN_W-1:0]  hold, hold_n;
  logic             hold_msb, hold_msb_n;
  logic             hold_full, hold_full_n;
  logic [OUT_W-1:0] data_n;
  logic             valid_n;
  logic             first_n;
  logic             acc;
  logic             idle;
  logic [OUT_W-1:0] slice;

  assign in_ready = reset & ~hold_full;
  assign acc      = in_valid & in_ready;
  assign idle     = (st == SER_IDLE);

  // From IDLE slice 0 comes straight off the input word.
  ser_slice_sel #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sel (
    .w   (idle ? in_data : cur),
    .k   (idle ? '0 : sel),
    .msb (idle ? in_msb_first : cur_msb),
    .s   (slice)
  );

  always_comb begin
    st_n        = st;
    cur_n       = cur;
    cur_msb_n   = cur_msb;
    sel_n       = sel;
    hold_n      = hold;
    hold_msb_n  = hold_msb;
    hold_full_n = hold_full;
    data_n      = FILL;
    valid_n     = 1'b0;
    first_n     = 1'b0;
    unique case (st)
      SER_IDLE: begin
        if (acc) begin
          cur_n     = in_data;
          cur_msb_n = in_msb_first;
          data_n    = slice;
          valid_n   = 1'b1;
          first_n   = 1'b1;
          sel_n     = SW'(1);
          st_n      = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        data_n  = slice;
        valid_n = 1'b1;
        first_n = (sel == '0);
        if (sel != LAST) begin
          sel_n = sel + SW'(1);
          if (acc) begin
            hold_n      = in_data;
            hold_msb_n  = in_msb_first;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          cur_n       = hold;
          cur_msb_n   = hold_msb;
          sel_n       = '0;
          hold_full_n = acc;
          if (acc) begin
            hold_n     = in_data;
            hold_msb_n = in_msb_first;
          end
        end else if (acc) begin
          cur_n     = in_data;
          cur_msb_n = in_msb_first;
          sel_n     = '0;
        end else begin
          st_n  = SER_IDLE;
          sel_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      st        <= SER_IDLE;
      sel       <= '0;
      hold_full <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
    end else begin
      st        <= st_n;
      sel       <= sel_n;
      hold_full <= hold_full_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_first <= first_n;
    end
  end

  always_ff @(posedge clk_4f) begin
    cur      <= cur_n;
    cur_msb  <= cur_msb_n;
    hold     <= hold_n;
    hold_msb <= hold_msb_n;
  end

endmodule

// File: tb/tb_ser_nto1.sv
// Bench for ser_nto1: directed table, corner sequences, random
// traffic against a slice-queue model, plus a 64/16 instance.
module tb_ser_nto1;

  localparam int RATIO = 4;
`ifdef SER_IDLE_FILL_EN
  localparam logic [7:0]  FILL8  = 8'hBC;
  localparam logic [15:0] FILL16 = 16'h00BC;
`else
  localparam logic [7:0]  FILL8  = 8'h00;
  localparam logic [15:0] FILL16 = 16'h0000;
`endif

  logic clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_msb_first;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_first;

  logic        reset2;
  logic [63:0] in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic        in_msb2;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic        out_first2;

  ser_nto1 dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_msb_first (in_msb_first),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_first    (out_first)
  );

  ser_nto1 #(
    .IN_W     (64),
    .OUT_W    (16),
    .IDLE_SYM (16'h00BC)
  ) dut2 (
    .clk_4f       (clk_4f),
    .reset        (reset2),
    .in_data      (in_data2),
    .in_valid     (in_valid2),
    .in_ready     (in_ready2),
    .in_msb_first (in_msb2),
    .out_data     (out_data2),
    .out_valid    (out_valid2),
    .out_first    (out_first2)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       first;
    logic [7:0] d;
  } slc_t;

  // Model: every accepted word appends its slices; one pops per cycle.
  slc_t       q[$];
  logic       ev;
  logic [7:0] ed;
  logic       ef;

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] d;
    logic        m;
    logic        xr;
    logic        xv;
    logic [7:0]  xd;
    logic        xf;
  } vec_t;

  vec_t tab[12];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(input  logic        r,
                     input  logic        v,
                     input  logic [31:0] d,
                     input  logic        m,
                     output logic        rdy_seen);
    logic rdy;
    slc_t s;
    @(negedge clk_4f);
    reset        = r;
    in_valid     = v;
    in_data      = d;
    in_msb_first = m;
    #1;
    rdy      = r && (q.size() <= RATIO);
    rdy_seen = in_ready;
    chk("in_ready", in_ready, rdy);
    @(posedge clk_4f);
    if (!r) begin
      q.delete();
      ev = 1'b0;
      ed = 8'h00;
      ef = 1'b0;
    end else begin
      if (v && rdy) begin
        for (int k = 0; k < RATIO; k++) begin
          s.first = (k == 0);
          s.d = m ? 8'(d >> (8 * (RATIO - 1 - k)))
                  : 8'(d >> (8 * k));
          q.push_back(s);
        end
      end
      if (q.size() > 0) begin
        s  = q.pop_front();
        ev = 1'b1;
        ed = s.d;
        ef = s.first;
      end else begin
        ev = 1'b0;
        ed = FILL8;
        ef = 1'b0;
      end
    end
    #1;
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("out_first", out_first, ef);
  endtask

  logic        rs;
  int          idx;
  int          run;
  int          maxrun;
  int          nval;
  logic [31:0] bw[3];
  logic [15:0] e2[5];

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b0;
    reset2       = 1'b0;
    in_valid2    = 1'b0;
    in_data2     = '0;
    in_msb2      = 1'b0;

    tab[0]  = '{1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 8'h00, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, FILL8, 1'b0};
    tab[2]  = '{1'b1, 1'b1, 32'hA1B2C3D4, 1'b1,
                1'b1, 1'b1, 8'hA1, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b1, 8'hB2, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b1, 8'hC3, 1'b0};
    tab[5]  = '{1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b1, 8'hD4, 1'b0};
    tab[6]  = '{1'b1, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, FILL8, 1'b0};
    tab[7]  = '{1'b1, 1'b1, 32'hA1B2C3D4, 1'b0,
                1'b1, 1'b1, 8'hD4, 1'b1};
    tab[8]  = '{1'b1, 1'b0, 32'h0, 1'b1,
                1'b1, 1'b1, 8'hC3, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 32'h0, 1'b1,
                1'b1, 1'b1, 8'hB2, 1'b0};
    tab[10] = '{1'b1, 1'b0, 32'h0, 1'b1,
                1'b1, 1'b1, 8'hA1, 1'b0};
    tab[11] = '{1'b1, 1'b0, 32'h0, 1'b1,
                1'b1, 1'b0, FILL8, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(tab[i].r, tab[i].v, tab[i].d, tab[i].m, rs);
      chk("tab_ready", rs, tab[i].xr);
      chk("tab_valid", out_valid, tab[i].xv);
      chk("tab_data", out_data, tab[i].xd);
      chk("tab_first", out_first, tab[i].xf);
    end

    // Three words with in_valid held: 12 slices, no gap.
    bw[0]  = 32'h11223344;
    bw[1]  = 32'h55667788;
    bw[2]  = 32'h99AABBCC;
    idx    = 0;
    run    = 0;
    maxrun = 0;
    nval   = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(1'b1, idx < 3, (idx < 3) ? bw[idx] : 32'h0, 1'b1, rs);
      if (idx < 3 && rs) idx++;
      if (out_valid) begin
        run++;
        nval++;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
    end
    chk("b2b_words", idx, 3);
    chk("b2b_slices", nval, 12);
    chk("b2b_run", maxrun, 12);

    // Reset after the 2nd slice with hold full.
    cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, rs);
    cyc(1'b1, 1'b1, 32'hCAFEF00D, 1'b0, rs);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, rs);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    nval = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, rs);
      if (out_valid) nval++;
    end
    chk("rst_drop", nval, 0);

    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 99) != 0,
          $urandom_range(0, 2) != 0,
          $urandom, 1'($urandom), rs);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, rs);

    // 64-to-16 instance, msb first, then idle.
    e2[0] = 16'h0011;
    e2[1] = 16'h2233;
    e2[2] = 16'h4455;
    e2[3] = 16'h6677;
    e2[4] = FILL16;
    @(negedge clk_4f);
    reset2 = 1'b0;
    @(posedge clk_4f);
    #1;
    chk("w64_rst_valid", out_valid2, 1'b0);
    chk("w64_rst_data", out_data2, 16'h0);
    @(negedge clk_4f);
    reset2    = 1'b1;
    in_valid2 = 1'b1;
    in_data2  = 64'h0011223344556677;
    in_msb2   = 1'b1;
    #1;
    chk("w64_ready", in_ready2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_4f);
      #1;
      chk("w64_data", out_data2, e2[k]);
      chk("w64_valid", out_valid2, k < 4);
      chk("w64_first", out_first2, k == 0);
      in_valid2 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
